// File: rtl/wta_bus_mux_p.sv
// wta_bus_mux_p: registered source-select mux with one-beat valid/ready output stage
module wta_bus_mux_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_SRC  = 15,
  parameter int SEL_W    = 8,
  parameter int SEL_BASE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          wta_sel,
  input  logic                      wta_en,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      out_ready,
  input  logic                      err_clr,
  output logic                      req_stall,
  output logic [DATA_W-1:0]         dataout,
  output logic                      out_valid,
  output logic                      out_err,
  output logic                      err_sticky,
  output logic [CNT_W-1:0]          xfer_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  localparam logic [SEL_W:0] SEL_LO = (SEL_W+1)'(SEL_BASE);
  localparam logic [SEL_W:0] SEL_N  = (SEL_W+1)'(NUM_SRC);
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   dataout_q, dataout_d, sel_word;
  logic                out_err_q, out_err_d, err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic [SEL_W:0]      offset;
  logic                in_range, accept, fire;
  // codes below SEL_BASE wrap to >= 2^SEL_W, so one compare covers both bounds
  assign offset    = {1'b0, wta_sel} - SEL_LO;
  assign in_range  = offset < SEL_N;
  assign out_valid = state_q == FULL;
  assign fire      = out_valid && out_ready;
  assign accept    = wta_en && (!out_valid || out_ready);
  assign req_stall = wta_en && out_valid && !out_ready;
  assign dataout    = dataout_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign xfer_cnt   = xfer_cnt_q;
  // source word addressed by the select; zero for out-of-range codes
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (offset == (SEL_W+1)'(k)) sel_word = src_data[k*DATA_W +: DATA_W];
  end
  // next state: load on accept, drain to zero on a bare fire, otherwise hold
  always_comb begin
    state_d      = state_q == EMPTY ? (wta_en ? FULL : EMPTY) : (fire && !wta_en ? EMPTY : FULL);
    dataout_d    = accept ? sel_word : fire ? '0 : dataout_q;
    out_err_d    = accept ? !in_range : fire ? 1'b0 : out_err_q;
    err_sticky_d = (accept && !in_range) || (err_sticky_q && !err_clr);
    xfer_cnt_d   = xfer_cnt_q + CNT_W'(fire);
  end
  // output stage and debug registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      dataout_q    <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      xfer_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      dataout_q    <= dataout_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end
endmodule

// File: tb/tb_wta_bus_mux_p.sv
// tb_wta_bus_mux_p: directed table, stall/error/reset/wrap sequences and random check vs a queue model
module tb_wta_bus_mux_p;
  logic         clk = 0, rst_n = 0;
  logic [7:0]   wta_sel = 0;
  logic         wta_en = 0, out_ready = 0, err_clr = 0;
  logic [239:0] src_data;
  logic         req_stall, out_valid, out_err, err_sticky;
  logic [15:0]  dataout, xfer_cnt;
  logic [7:0]   sel2 = 0;
  logic         en2 = 0, rdy2 = 1, clr2 = 0;
  logic [127:0] src2;
  logic         stall2, valid2, err2, sticky2;
  logic [31:0]  data2;
  logic [15:0]  cnt2;
  int total = 0, bad = 0;
  wta_bus_mux_p u_dut (
    .clk(clk), .rst_n(rst_n), .wta_sel(wta_sel), .wta_en(wta_en), .src_data(src_data),
    .out_ready(out_ready), .err_clr(err_clr), .req_stall(req_stall), .dataout(dataout),
    .out_valid(out_valid), .out_err(out_err), .err_sticky(err_sticky), .xfer_cnt(xfer_cnt)
  );
  wta_bus_mux_p #(.DATA_W(32), .NUM_SRC(4), .SEL_BASE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wta_sel(sel2), .wta_en(en2), .src_data(src2),
    .out_ready(rdy2), .err_clr(clr2), .req_stall(stall2), .dataout(data2),
    .out_valid(valid2), .out_err(err2), .err_sticky(sticky2), .xfer_cnt(cnt2)
  );
  always #5 clk = ~clk;
  // reference: the output stage is a queue holding at most one beat
  typedef struct { logic [15:0] d; logic e; } beat_t;
  beat_t       mq[$];
  logic [15:0] m_cnt = 0;
  logic        m_sticky = 0, m_fire, m_acc, m_ir;
  int          m_idx;
  function automatic logic [15:0] src_word(input int k);
    return src_data[k*16 +: 16];
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0;
      m_sticky = 0;
    end else begin
      m_idx = int'(wta_sel) - 1;
      m_ir = m_idx >= 0 && m_idx < 15;
      m_fire = mq.size() != 0 && out_ready;
      m_acc = wta_en && (mq.size() == 0 || out_ready);
      m_sticky = (m_acc && !m_ir) || (m_sticky && !err_clr);
      if (m_fire) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (m_acc) mq.push_back('{m_ir ? src_word(m_idx) : 16'h0, !m_ir});
    end
  end
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk(input string tag);
    logic [15:0] ed;
    ed = mq.size() != 0 ? mq[0].d : 16'h0;
    cmp({tag, ".data"}, 32'(dataout), 32'(ed));
    cmp({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    cmp({tag, ".err"}, 32'(out_err), 32'(mq.size() != 0 && mq[0].e));
    cmp({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
    cmp({tag, ".cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    cmp({tag, ".stall"}, 32'(req_stall), 32'(wta_en && mq.size() != 0 && !out_ready));
  endtask
  typedef struct { logic en; logic [7:0] sel; logic rdy; logic clr; logic [15:0] d; logic v, e, s; logic [15:0] c; } vec_t;
  vec_t tv[11];
  initial begin
    tv[0]  = '{1, 8'd1,  1, 0, 16'h1000, 1, 0, 0, 16'd0};
    tv[1]  = '{0, 8'd1,  1, 0, 16'h0000, 0, 0, 0, 16'd1};
    tv[2]  = '{1, 8'd15, 1, 0, 16'h100E, 1, 0, 0, 16'd1};
    tv[3]  = '{1, 8'd3,  1, 0, 16'h1002, 1, 0, 0, 16'd2};
    tv[4]  = '{1, 8'd7,  1, 0, 16'h1006, 1, 0, 0, 16'd3};
    tv[5]  = '{0, 8'd7,  1, 0, 16'h0000, 0, 0, 0, 16'd4};
    tv[6]  = '{1, 8'd0,  1, 0, 16'h0000, 1, 1, 1, 16'd4};
    tv[7]  = '{1, 8'd16, 1, 0, 16'h0000, 1, 1, 1, 16'd5};
    tv[8]  = '{1, 8'd0,  1, 1, 16'h0000, 1, 1, 1, 16'd6};
    tv[9]  = '{0, 8'd0,  1, 1, 16'h0000, 0, 0, 0, 16'd7};
    tv[10] = '{1, 8'd5,  1, 0, 16'h1004, 1, 0, 0, 16'd7};
    for (int k = 0; k < 15; k++) src_data[k*16 +: 16] = 16'h1000 + 16'(k);
    for (int k = 0; k < 4; k++) src2[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    @(posedge clk);
    #1;
    cmp("rst.data", 32'(dataout), 0);
    cmp("rst.valid", 32'(out_valid), 0);
    cmp("rst.err", 32'(out_err), 0);
    cmp("rst.sticky", 32'(err_sticky), 0);
    cmp("rst.cnt", 32'(xfer_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      en2 = 1;
      sel2 = 8'(k);
      @(posedge clk);
      #1;
      cmp($sformatf("w32.sel%0d.data", k), data2, k < 4 ? 32'hA000_0000 + 32'(k) : 32'h0);
      cmp($sformatf("w32.sel%0d.err", k), 32'(err2), 32'(k == 4));
    end
    @(negedge clk);
    en2 = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      wta_en = tv[i].en;
      wta_sel = tv[i].sel;
      out_ready = tv[i].rdy;
      err_clr = tv[i].clr;
      @(posedge clk);
      #1;
      cmp($sformatf("tv%0d.data", i), 32'(dataout), 32'(tv[i].d));
      cmp($sformatf("tv%0d.valid", i), 32'(out_valid), 32'(tv[i].v));
      cmp($sformatf("tv%0d.err", i), 32'(out_err), 32'(tv[i].e));
      cmp($sformatf("tv%0d.sticky", i), 32'(err_sticky), 32'(tv[i].s));
      cmp($sformatf("tv%0d.cnt", i), 32'(xfer_cnt), 32'(tv[i].c));
      chk($sformatf("tv%0d", i));
    end
    @(negedge clk);
    out_ready = 0;
    wta_en = 1;
    wta_sel = 8'd9;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) src_data[4*16 +: 16] = 16'hBEEF;
      #1;
      cmp("stall.data", 32'(dataout), 32'h1004);
      cmp("stall.req", 32'(req_stall), 1);
      chk("stall");
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    cmp("unstall.data", 32'(dataout), 32'h1008);
    cmp("unstall.valid", 32'(out_valid), 1);
    cmp("unstall.cnt", 32'(xfer_cnt), 8);
    @(negedge clk);
    src_data[4*16 +: 16] = 16'h1004;
    out_ready = 0;
    wta_sel = 8'd2;
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    cmp("arst.data", 32'(dataout), 0);
    cmp("arst.valid", 32'(out_valid), 0);
    cmp("arst.err", 32'(out_err), 0);
    cmp("arst.cnt", 32'(xfer_cnt), 0);
    chk("arst");
    @(negedge clk);
    wta_en = 0;
    out_ready = 1;
    rst_n = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      wta_en = $urandom_range(0, 3) != 0;
      wta_sel = 8'($urandom_range(0, 17));
      out_ready = $urandom_range(0, 2) != 0;
      err_clr = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = int'($urandom_range(0, 14));
        src_data[k*16 +: 16] = 16'($urandom);
      end
      #1;
      chk("rnd");
    end
    @(negedge clk);
    wta_en = 1;
    wta_sel = 8'd1;
    out_ready = 1;
    err_clr = 0;
    for (int i = 0; i < 70000 && !(m_cnt == 16'hFFFF && mq.size() != 0); i++) @(negedge clk);
    cmp("wrap.pre", 32'(xfer_cnt), 32'hFFFF);
    @(posedge clk);
    #1;
    cmp("wrap.post", 32'(xfer_cnt), 0);
    chk("wrap");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
